// File: rtl/exp_pkg.sv
// Shared definitions for the exponential-scaling unit: state encoding,
// default widths and the output-width helper.
package exp_pkg;

  // Default widths
  localparam int XW_DEF = 16;
  localparam int IW_DEF = 2;
  localparam int FW_DEF = 16;
  localparam int SW_DEF = 2;

  // Sequencer states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } exp_state_e;

  // Plain-vector aliases so the state register stays a simple logic vector
  localparam logic [1:0] ST_IDLE  = S_IDLE;
  localparam logic [1:0] ST_START = S_START;
  localparam logic [1:0] ST_WAIT  = S_WAIT;
  localparam logic [1:0] ST_DONE  = S_DONE;

  // Output width: room for the engine result plus the largest left shift
  function automatic int calc_ow(input int iw, input int fw, input int sw);
    return iw + fw + (1 << sw) - 1;
  endfunction

endpackage

// File: rtl/scale_shifter.sv
// Combinational barrel left-shift of the engine result {int,frac} into the
// wider output field. Low bits fill with zero.
module scale_shifter
  import exp_pkg::*;
#(
  parameter int IW = IW_DEF,
  parameter int FW = FW_DEF,
  parameter int SW = SW_DEF,
  localparam int OW = calc_ow(IW, FW, SW)
) (
  input  logic [IW+FW-1:0] din,
  input  logic [SW-1:0]    sh,
  output logic [OW-1:0]    dout
);

  // Zero-extend first; OW leaves headroom for the largest shift, so no bit is lost
  always_comb begin
    dout = {OW{1'b0}};
    dout = OW'(din) << sh;
  end

endmodule

// File: rtl/exp_scale_unit.sv
// Exponential-scaling datapath with its own sequencer. Takes an operand and
// shift code, runs an external exponential engine via start/done, shifts the
// fixed-point result and presents it on a registered valid/ready output.
// A completed result can wait in DONE while the output register is stalled.
// Optional feature macro: EXP_TIMEOUT_EN (bounded WAIT with error result).
module exp_scale_unit
  import exp_pkg::*;
#(
  parameter int XW      = XW_DEF,
  parameter int IW      = IW_DEF,
  parameter int FW      = FW_DEF,
  parameter int SW      = SW_DEF,
  parameter int TIMEOUT = 1023,
  localparam int OW     = calc_ow(IW, FW, SW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [XW-1:0] in_x,
  input  logic [SW-1:0] in_shift,
  output logic          eng_start,
  output logic [XW-1:0] eng_x,
  input  logic          eng_done,
  input  logic [IW-1:0] eng_int,
  input  logic [FW-1:0] eng_frac,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          out_err
);

  logic [1:0]    state;
  logic [XW-1:0] x_reg;
  logic [SW-1:0] sh_reg;
  logic [OW-1:0] res_reg;
  logic          err_reg;
  logic [OW-1:0] shifted;
  logic          expire;

  scale_shifter #(.IW(IW), .FW(FW), .SW(SW)) u_shifter (
    .din  ({eng_int, eng_frac}),
    .sh   (sh_reg),
    .dout (shifted)
  );

  assign in_ready = (state == ST_IDLE);
  assign eng_x    = x_reg;

`ifdef EXP_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt;

  // Expiry lands on the edge that closes the TIMEOUT-th WAIT cycle
  assign expire = (to_cnt == CW'(TIMEOUT - 1));

  // Count WAIT cycles so a silent engine cannot hang the unit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= {CW{1'b0}};
    end else if (state == ST_WAIT) begin
      to_cnt <= to_cnt + CW'(1);
    end else begin
      to_cnt <= {CW{1'b0}};
    end
  end
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT != 0);
  assign expire = 1'b0;
`endif

  // Sequencer, operand/result capture and the registered output stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      x_reg     <= {XW{1'b0}};
      sh_reg    <= {SW{1'b0}};
      res_reg   <= {OW{1'b0}};
      err_reg   <= 1'b0;
      eng_start <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= {OW{1'b0}};
      out_err   <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      // Consumption clears valid; a reload below in the same cycle overrides it
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x_reg     <= in_x;
            sh_reg    <= in_shift;
            eng_start <= 1'b1;
            state     <= ST_START;
          end
        end
        ST_START: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done arriving together with expiry still yields a normal result
          if (eng_done) begin
            res_reg <= shifted;
            err_reg <= 1'b0;
            state   <= ST_DONE;
          end else if (expire) begin
            res_reg <= {OW{1'b1}};
            err_reg <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!out_valid || out_ready) begin
            out_data  <= res_reg;
            out_err   <= err_reg;
            out_valid <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exp_scale_unit.sv
// Self-checking bench for exp_scale_unit: directed scenarios plus randomized
// traffic against a queue-based reference model and a behavioural engine.
module tb_exp_scale_unit;

  localparam int XW = 16;
  localparam int IW = 2;
  localparam int FW = 16;
  localparam int SW = 2;
  localparam int OW = IW + FW + 2**SW - 1;
`ifdef EXP_TIMEOUT_EN
  localparam int TB_TIMEOUT = 8;
`else
  localparam int TB_TIMEOUT = 1023;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [XW-1:0] in_x = '0;
  logic [SW-1:0] in_shift = '0;
  logic          eng_start;
  logic [XW-1:0] eng_x;
  logic          eng_done = 1'b0;
  logic [IW-1:0] eng_int = '0;
  logic [FW-1:0] eng_frac = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic          out_err;

  int vectors = 0;
  int miscompares = 0;
  int starts = 0;

  // Engine / environment controls
  bit            rnd_ready = 1'b0;
  bit            silent = 1'b0;
  bit            stray_idle = 1'b0;
  bit            stray_start = 1'b0;
  bit            force_en = 1'b0;
  int            eng_delay = 1;
  logic [IW-1:0] f_int = '0;
  logic [FW-1:0] f_frac = '0;

  // Reference model state
  logic [XW-1:0] acc_x[$];
  logic [SW-1:0] acc_sh[$];
  logic [OW-1:0] exp_d[$];
  logic          exp_e[$];

  exp_scale_unit #(.XW(XW), .IW(IW), .FW(FW), .SW(SW), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_shift(in_shift),
    .eng_start(eng_start), .eng_x(eng_x), .eng_done(eng_done),
    .eng_int(eng_int), .eng_frac(eng_frac),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // Scaled value = (int + frac/2^FW) * 2^FW * 2^shift, as an integer
  function automatic logic [OW-1:0] model_result(input int unsigned i, input int unsigned f,
                                                 input int unsigned sh);
    longint unsigned v;
    v = (longint'(i) * (2**FW) + longint'(f)) * (longint'(1) << sh);
    return v[OW-1:0];
  endfunction

  // Behavioural engine plus output scoreboard, evaluated on falling edges
  task automatic engine_and_monitor();
    int cnt = 0;
    logic [XW-1:0] cur_x = '0;
    logic [SW-1:0] cur_sh = '0;
    logic [IW-1:0] ri;
    logic [FW-1:0] rf;
    logic [OW-1:0] ed;
    logic ee;
    forever begin
      @(negedge clk);
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      eng_done = 1'b0;
      if (!rst) begin
        cnt = 0;
        acc_x.delete(); acc_sh.delete(); exp_d.delete(); exp_e.delete();
      end else begin
        if (out_valid && out_ready) begin
          vectors++;
          if (exp_d.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_output: out_data=%h out_err=%b, required no output", out_data, out_err);
          end else begin
            ed = exp_d.pop_front();
            ee = exp_e.pop_front();
            if (out_data !== ed || out_err !== ee) begin
              miscompares++;
              $display("FAIL scoreboard: out_data=%h out_err=%b, required %h %b", out_data, out_err, ed, ee);
            end
          end
        end
        if (stray_idle) begin
          eng_done = 1'b1; eng_int = 2'd3; eng_frac = 16'hFFFF;
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            if (force_en) begin ri = f_int; rf = f_frac; end
            else begin ri = IW'($urandom); rf = FW'($urandom); end
            eng_int = ri; eng_frac = rf; eng_done = 1'b1;
            exp_d.push_back(model_result(ri, rf, cur_sh));
            exp_e.push_back(1'b0);
          end
        end
        if (eng_start === 1'b1) begin
          starts++;
          vectors++;
          if (acc_x.size() == 0) begin
            miscompares++;
            $display("FAIL start_without_operand: eng_start=1, required 0");
          end else begin
            cur_x = acc_x.pop_front();
            cur_sh = acc_sh.pop_front();
            if (eng_x !== cur_x) begin
              miscompares++;
              $display("FAIL eng_x: got %h, required %h", eng_x, cur_x);
            end
          end
          if (silent) begin
            cnt = 0;
            exp_d.push_back({OW{1'b1}});
            exp_e.push_back(1'b1);
          end else begin
            cnt = eng_delay;
            if (stray_start) begin
              eng_done = 1'b1; eng_int = 2'd3; eng_frac = 16'hFFFF;
            end
          end
        end
        if (in_valid && in_ready) begin
          acc_x.push_back(in_x);
          acc_sh.push_back(in_shift);
        end
      end
    end
  endtask

  // Offer one operand; return just after the accepting edge
  task automatic send(input logic [XW-1:0] x, input logic [SW-1:0] sh, output bit ok);
    int n = 0;
    ok = 1'b0;
    in_valid = 1'b1; in_x = x; in_shift = sh;
    while (n < 300 && !ok) begin
      @(negedge clk);
      n++;
      if (in_ready === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
    end
  endtask

  // Wait for out_valid; n = edges elapsed since the call
  task automatic wait_out(output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < 100 && !ok) begin
      @(posedge clk); #1;
      n++;
      if (out_valid === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL out_valid_timeout: out_valid=%b, required 1", out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 21'h0 || out_err !== 1'b0 || eng_start !== 1'b0 || eng_x !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b data=%h err=%b start=%b x=%h, required all 0",
               out_valid, out_data, out_err, eng_start, eng_x);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int s0;
    force_en = 1'b1; f_int = 2'd1; f_frac = 16'h8000; eng_delay = 1;
    out_ready = 1'b1; rnd_ready = 1'b0;
    s0 = starts;
    send(16'h1234, 2'd2, ok);
    vectors++;
    if (eng_start !== 1'b1 || eng_x !== 16'h1234) begin
      miscompares++;
      $display("FAIL start_pulse: start=%b x=%h, required 1 1234", eng_start, eng_x);
    end
    @(posedge clk); #1;
    vectors++;
    if (eng_start !== 1'b0) begin
      miscompares++;
      $display("FAIL start_once: got %b, required 0", eng_start);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_early: out_valid=%b, required 0", out_valid);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 21'h060000 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_result: valid=%b data=%h err=%b, required 1 060000 0", out_valid, out_data, out_err);
    end
    @(posedge clk); #1;
    vectors++;
    if (starts - s0 != 1) begin
      miscompares++;
      $display("FAIL start_count: got %0d, required 1", starts - s0);
    end
  endtask

  task automatic test_shift();
    logic [SW-1:0] sh_tab[2];
    logic [OW-1:0] exp_tab[2];
    bit ok;
    int n;
    sh_tab[0] = 2'd3; exp_tab[0] = 21'h1FFFF8;
    sh_tab[1] = 2'd0; exp_tab[1] = 21'h03FFFF;
    force_en = 1'b1; f_int = 2'd3; f_frac = 16'hFFFF; eng_delay = 2;
    for (int k = 0; k < 2; k++) begin
      send(16'h0F0F, sh_tab[k], ok);
      wait_out(n, ok);
      vectors++;
      if (out_data !== exp_tab[k] || out_err !== 1'b0) begin
        miscompares++;
        $display("FAIL shift_%0d: data=%h err=%b, required %h 0", k, out_data, out_err, exp_tab[k]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    out_ready = 1'b0; rnd_ready = 1'b0; force_en = 1'b1; eng_delay = 1;
    f_int = 2'd2; f_frac = 16'h1234;
    send(16'h00AA, 2'd1, ok);
    wait_out(n, ok);
    f_int = 2'd1; f_frac = 16'h0001;
    send(16'h00BB, 2'd3, ok);
    repeat (8) @(posedge clk);
    #1;
    in_valid = 1'b1; in_x = 16'h00CC; in_shift = 2'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_in_ready: got %b, required 0", in_ready);
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 21'h042468) begin
      miscompares++;
      $display("FAIL stall_hold: valid=%b data=%h, required 1 042468", out_valid, out_data);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 21'h080008) begin
      miscompares++;
      $display("FAIL drain_second: valid=%b data=%h, required 1 080008", out_valid, out_data);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_empty: valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_stray_done();
    bit ok;
    int n;
    int s0;
    out_ready = 1'b1; force_en = 1'b1; f_int = 2'd1; f_frac = 16'h0100;
    s0 = starts;
    stray_idle = 1'b1;
    @(posedge clk); #1;
    stray_idle = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || starts != s0) begin
      miscompares++;
      $display("FAIL stray_idle: valid=%b starts=%0d, required 0 %0d", out_valid, starts, s0);
    end
    stray_start = 1'b1; eng_delay = 2;
    send(16'h0042, 2'd1, ok);
    wait_out(n, ok);
    stray_start = 1'b0;
    vectors++;
    if (n != 4 || out_data !== 21'h020200 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL stray_start: edges=%0d data=%h err=%b, required 4 020200 0", n, out_data, out_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    bit ok;
    int n;
    force_en = 1'b0; rnd_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      eng_delay = $urandom_range(1, 5);
      send(XW'($urandom), SW'($urandom_range(0, 3)), ok);
    end
    rnd_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    n = 0;
    while (n < 200 && (exp_d.size() != 0 || acc_x.size() != 0 || in_ready !== 1'b1)) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (exp_d.size() != 0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL random_drain: pending=%0d valid=%b, required 0 0", exp_d.size(), out_valid);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    int n;
    out_ready = 1'b1; force_en = 1'b0; eng_delay = 50;
    send(16'hBEEF, 2'd1, ok);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_data !== 21'h0 || out_err !== 1'b0 || eng_start !== 1'b0 ||
        eng_x !== 16'h0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_reset: valid=%b data=%h err=%b start=%b x=%h rdy=%b, required 0 0 0 0 0 1",
               out_valid, out_data, out_err, eng_start, eng_x, in_ready);
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset_release: rdy=%b valid=%b, required 1 0", in_ready, out_valid);
    end
    eng_delay = 1;
    send(16'h5555, 2'd2, ok);
    wait_out(n, ok);
    @(posedge clk); #1;
  endtask

`ifdef EXP_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int n;
    out_ready = 1'b1; silent = 1'b1;
    send(16'h7777, 2'd1, ok);
    wait_out(n, ok);
    silent = 1'b0;
    vectors++;
    if (n != TB_TIMEOUT + 2 || out_data !== 21'h1FFFFF || out_err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout: edges=%0d data=%h err=%b, required %0d 1fffff 1", n, out_data, out_err, TB_TIMEOUT + 2);
    end
    @(posedge clk); #1;
    stray_idle = 1'b1;
    @(posedge clk); #1;
    stray_idle = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL late_done: valid=%b rdy=%b, required 0 1", out_valid, in_ready);
    end
  endtask
`endif

  initial begin
    fork
      engine_and_monitor();
    join_none
    test_reset();
    test_basic();
    test_shift();
    test_back_to_back();
    test_stray_done();
    test_random();
    test_mid_reset();
`ifdef EXP_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
